tetris_board_renderer: RTL and testbench

Pixel-generation stage sitting directly downstream of the VGA sync generator. It consumes the pixel coordinates, `video_on`, sync and pixel-tick outputs and produces registered 12-bit RGB for a 10×20 Tetris playfield. The playfield comes from an external synchronous board RAM and is overlaid with the active falling piece. Sync outputs are delayed to stay aligned with the pipelined RGB.

---
 rtl/tetris_pkg.sv | 30 +++
 rtl/tetris_board_renderer_if.sv | 40 ++++
 rtl/tetris_palette.sv | 41 ++++
 rtl/tetris_board_renderer.sv | 170 +++++++++++++++++
 tb/tb_tetris_board_renderer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: constants and types shared by the Tetris renderer, game logic
// and board RAM. Holds the playfield geometry, the frame line on which the
// falling piece is latched, the colour-index type and the 8-entry palette.
package tetris_pkg;

    localparam int BOARD_COLS = 32'd10;
    localparam int BOARD_ROWS = 32'd20;
    localparam int CELL_SHIFT = 32'd4;

    // Piece inputs are sampled once per frame at this pixel (below the board).
    localparam logic [9:0] LATCH_X = 10'd0;
    localparam logic [9:0] LATCH_Y = 10'd480;

    typedef logic [2:0] color_idx_t;

    localparam logic [11:0] PAL_EMPTY  = 12'h111;
    localparam logic [11:0] PAL_CYAN   = 12'h0FF;
    localparam logic [11:0] PAL_YELLOW = 12'hFF0;
    localparam logic [11:0] PAL_PURPLE = 12'hA0F;
    localparam logic [11:0] PAL_GREEN  = 12'h0F0;
    localparam logic [11:0] PAL_RED    = 12'hF00;
    localparam logic [11:0] PAL_BLUE   = 12'h00F;
    localparam logic [11:0] PAL_ORANGE = 12'hF80;

    // Halve each 4-bit channel (used for the cell bevel).
    function automatic logic [11:0] half_bright(input logic [11:0] c);
        return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    endfunction

endpackage

// File: rtl/tetris_board_renderer_if.sv
// tetris_board_renderer_if: bundles the renderer's video, board-RAM and
// piece signals.
//   video in : p_tick, x, y, video_on, hsync_in, vsync_in
//   board RAM: cell_addr (out of renderer), cell_data (into renderer)
//   piece    : piece_en, piece_mask, piece_row, piece_col, piece_color
//   video out: rgb, hsync_out, vsync_out
// master = the environment (sync generator, RAM, game logic); slave = renderer.
interface tetris_board_renderer_if;
    import tetris_pkg::*;

    logic        p_tick;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [7:0]  cell_addr;
    color_idx_t  cell_data;
    logic        piece_en;
    logic [15:0] piece_mask;
    logic [4:0]  piece_row;
    logic [3:0]  piece_col;
    color_idx_t  piece_color;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;

    modport master (
        output p_tick, x, y, video_on, hsync_in, vsync_in, cell_data,
               piece_en, piece_mask, piece_row, piece_col, piece_color,
        input  cell_addr, rgb, hsync_out, vsync_out
    );

    modport slave (
        input  p_tick, x, y, video_on, hsync_in, vsync_in, cell_data,
               piece_en, piece_mask, piece_row, piece_col, piece_color,
        output cell_addr, rgb, hsync_out, vsync_out
    );

endinterface

// File: rtl/tetris_palette.sv
// tetris_palette: combinational colour-index to 12-bit RGB lookup with an
// optional half-brightness output.
//   idx  : colour index (0 = empty cell)
//   half : when set, every channel is shifted right by one
//   rgb  : {R[3:0],G[3:0],B[3:0]}
module tetris_palette
    import tetris_pkg::*;
(
    input  color_idx_t  idx,
    input  logic        half,
    output logic [11:0] rgb
);

    logic [11:0] base_s;

    // Palette lookup.
    always_comb begin
        base_s = PAL_EMPTY;
        case (idx)
            3'd0:    base_s = PAL_EMPTY;
            3'd1:    base_s = PAL_CYAN;
            3'd2:    base_s = PAL_YELLOW;
            3'd3:    base_s = PAL_PURPLE;
            3'd4:    base_s = PAL_GREEN;
            3'd5:    base_s = PAL_RED;
            3'd6:    base_s = PAL_BLUE;
            3'd7:    base_s = PAL_ORANGE;
            default: base_s = PAL_EMPTY;
        endcase
    end

    // Optional bevel dimming.
    always_comb begin
        if (half) begin
            rgb = half_bright(base_s);
        end else begin
            rgb = base_s;
        end
    end

endmodule

// File: rtl/tetris_board_renderer.sv
// tetris_board_renderer: two-stage pixel pipeline that draws a framed 10x20
// Tetris playfield from an external synchronous board RAM, overlays the
// falling piece and delays the syncs to match.
//   clk   : system clock (2x pixel rate)
//   reset : asynchronous, active-high
//   bus   : slave side of tetris_board_renderer_if (video in/out, RAM, piece)
// Stage 1 (on p_tick) registers the RAM address, region flags, piece hit and
// in-cell offsets; the RAM answers on the following non-tick clk; stage 2 (next
// p_tick) registers the final colour and the syncs.
module tetris_board_renderer
    import tetris_pkg::*;
#(
    parameter logic [9:0] BOARD_X0 = 10'd240,
    parameter logic [9:0] BOARD_Y0 = 10'd80,
    parameter logic [9:0] BORDER_W = 10'd4
)(
    input logic                     clk,
    input logic                     reset,
    tetris_board_renderer_if.slave  bus
);

    localparam logic [9:0] BOARD_W = 10'(BOARD_COLS << CELL_SHIFT);
    localparam logic [9:0] BOARD_H = 10'(BOARD_ROWS << CELL_SHIFT);

    // Per-frame shadow of the piece inputs.
    logic        piece_en_r;
    logic [15:0] piece_mask_r;
    logic [4:0]  piece_row_r;
    logic [3:0]  piece_col_r;
    color_idx_t  piece_color_r;

    // Stage 1 combinational terms.
    logic [9:0]  dx_s;
    logic [9:0]  dy_s;
    logic        in_board_s;
    logic        in_frame_s;
    logic [3:0]  col_s;
    logic [4:0]  row_s;
    logic [7:0]  addr_s;
    logic [4:0]  dr_s;
    logic [4:0]  dc_s;
    logic        hit_s;
    logic        latch_s;

    // Stage 1 registers.
    logic [7:0]  cell_addr_r;
    logic        vis_r;
    logic        border_r;
    logic        board_r;
    logic        hit_r;
    logic [3:0]  lx_r;
    logic [3:0]  ly_r;
    logic        hs_r;
    logic        vs_r;

    // Stage 2 terms and registers.
    color_idx_t  idx_s;
    logic        edge_s;
    logic        half_s;
    logic [11:0] pal_s;
    logic [11:0] rgb_s;
    logic [11:0] rgb_r;
    logic        hsync_r;
    logic        vsync_r;

    // Offsets wrap for pixels left of/above the board; the >= tests reject them.
    assign dx_s       = bus.x - BOARD_X0;
    assign dy_s       = bus.y - BOARD_Y0;
    assign in_board_s = (bus.x >= BOARD_X0) && (dx_s < BOARD_W) &&
                        (bus.y >= BOARD_Y0) && (dy_s < BOARD_H);
    assign in_frame_s = (bus.x + BORDER_W >= BOARD_X0) && (bus.x < BOARD_X0 + BOARD_W + BORDER_W) &&
                        (bus.y + BORDER_W >= BOARD_Y0) && (bus.y < BOARD_Y0 + BOARD_H + BORDER_W);
    assign col_s      = dx_s[7:4];
    assign row_s      = dy_s[8:4];
    // row*10 as row*8 + row*2, kept in 8 bits.
    assign addr_s     = {row_s, 3'b000} + {2'b00, row_s, 1'b0} + {4'b0000, col_s};

    // Negative differences wrap to >=13, so the upper-bit test rejects them.
    assign dr_s  = row_s - piece_row_r;
    assign dc_s  = {1'b0, col_s} - {1'b0, piece_col_r};
    assign hit_s = piece_en_r && (dr_s[4:2] == 3'b000) && (dc_s[4:2] == 3'b000) &&
                   piece_mask_r[{dr_s[1:0], dc_s[1:0]}];

    assign latch_s = bus.p_tick && (bus.x == LATCH_X) && (bus.y == LATCH_Y);

    // Shadow the piece inputs once per frame, outside the board, so it never tears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            piece_en_r    <= 1'b0;
            piece_mask_r  <= 16'h0000;
            piece_row_r   <= 5'd0;
            piece_col_r   <= 4'd0;
            piece_color_r <= 3'd0;
        end else if (latch_s) begin
            piece_en_r    <= bus.piece_en;
            piece_mask_r  <= bus.piece_mask;
            piece_row_r   <= bus.piece_row;
            piece_col_r   <= bus.piece_col;
            piece_color_r <= bus.piece_color;
        end
    end

    // Stage 1: address the RAM and capture everything stage 2 needs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cell_addr_r <= 8'd0;
            vis_r       <= 1'b0;
            border_r    <= 1'b0;
            board_r     <= 1'b0;
            hit_r       <= 1'b0;
            lx_r        <= 4'd0;
            ly_r        <= 4'd0;
            hs_r        <= 1'b0;
            vs_r        <= 1'b0;
        end else if (bus.p_tick) begin
            cell_addr_r <= addr_s;
            vis_r       <= bus.video_on;
            border_r    <= in_frame_s && !in_board_s;
            board_r     <= in_board_s;
            hit_r       <= hit_s;
            lx_r        <= dx_s[3:0];
            ly_r        <= dy_s[3:0];
            hs_r        <= bus.hsync_in;
            vs_r        <= bus.vsync_in;
        end
    end

    assign idx_s  = hit_r ? piece_color_r : bus.cell_data;
    assign edge_s = (lx_r == 4'd0) || (lx_r == 4'd15) || (ly_r == 4'd0) || (ly_r == 4'd15);
    assign half_s = edge_s && (idx_s != 3'd0);

    tetris_palette u_palette (
        .idx  (idx_s),
        .half (half_s),
        .rgb  (pal_s)
    );

    // Colour priority: blanking, frame, outside, then cell/piece colour.
    always_comb begin
        rgb_s = 12'h000;
        if (!vis_r) begin
            rgb_s = 12'h000;
        end else if (border_r) begin
            rgb_s = 12'hFFF;
        end else if (!board_r) begin
            rgb_s = 12'h000;
        end else begin
            rgb_s = pal_s;
        end
    end

    // Stage 2: register the pixel and the matching syncs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_r   <= 12'h000;
            hsync_r <= 1'b0;
            vsync_r <= 1'b0;
        end else if (bus.p_tick) begin
            rgb_r   <= rgb_s;
            hsync_r <= hs_r;
            vsync_r <= vs_r;
        end
    end

    assign bus.cell_addr = cell_addr_r;
    assign bus.rgb       = rgb_r;
    assign bus.hsync_out = hsync_r;
    assign bus.vsync_out = vsync_r;

endmodule

// File: tb/tb_tetris_board_renderer.sv
// tb_tetris_board_renderer: self-checking bench for tetris_board_renderer.
// Each pixel tick pushes its expected {rgb, hsync, vsync} into a queue; the
// entry is popped and compared after the following tick, and again after the
// intervening non-tick clk to confirm the outputs hold.
module tb_tetris_board_renderer;
    import tetris_pkg::*;

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    typedef struct {
        int          x;
        int          y;
        bit          vo;
        bit          hs;
        bit          vs;
        logic [11:0] rgb;
        int          addr;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tetris_board_renderer_if bus ();

    tetris_board_renderer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous board RAM model: data one clk after the address.
    logic [2:0] ram [256];
    always @(posedge clk) bus.cell_data <= ram[bus.cell_addr];

    logic [11:0] pal_tb [8] = '{12'h111, 12'h0FF, 12'hFF0, 12'hA0F,
                                12'h0F0, 12'hF00, 12'h00F, 12'hF80};

    exp_t q[$];
    vec_t tbl[18];
    int checks = 0;
    int errors = 0;

    // Reference copy of the per-frame piece shadow.
    bit          m_en;
    logic [15:0] m_mask;
    int          m_row;
    int          m_col;
    logic [2:0]  m_color;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] model(input int px, input int py, input bit vo);
        int bx, by, row, col, lx, ly, mr, mc;
        logic [2:0]  idx;
        logic [11:0] c;
        bit inb, outer;
        if (!vo) return 12'h000;
        bx = px - 240;
        by = py - 80;
        inb   = (bx >= 0) && (bx < 160) && (by >= 0) && (by < 320);
        outer = (px >= 236) && (px <= 403) && (py >= 76) && (py <= 403);
        if (outer && !inb) return 12'hFFF;
        if (!inb) return 12'h000;
        col = bx / 16;  row = by / 16;
        lx  = bx % 16;  ly  = by % 16;
        idx = ram[row * 10 + col];
        mr = row - m_row;
        mc = col - m_col;
        if (m_en && mr >= 0 && mr < 4 && mc >= 0 && mc < 4 && m_mask[mr * 4 + mc])
            idx = m_color;
        c = pal_tb[idx];
        if (idx != 3'd0 && (lx == 0 || lx == 15 || ly == 0 || ly == 15))
            c = {c[11:8] >> 1, c[7:4] >> 1, c[3:0] >> 1};
        return c;
    endfunction

    task automatic clear_model();
        m_en = 1'b0; m_mask = 16'h0000; m_row = 0; m_col = 0; m_color = 3'd0;
        q.delete();
        q.push_back('{12'h000, 1'b0, 1'b0});
    endtask

    // One pixel tick followed by one idle clk.
    task automatic drive(input int px, input int py, input bit vo, input bit hs,
                         input bit vs, input logic [11:0] er);
        exp_t e, got;
        bit have;
        have = 1'b0;
        @(negedge clk);
        bus.x = 10'(px);  bus.y = 10'(py);
        bus.video_on = vo; bus.hsync_in = hs; bus.vsync_in = vs;
        bus.p_tick = 1'b1;
        e.rgb = er; e.hs = hs; e.vs = vs;
        q.push_back(e);
        if (px == 0 && py == 480) begin
            m_en = bus.piece_en; m_mask = bus.piece_mask;
            m_row = int'(bus.piece_row); m_col = int'(bus.piece_col);
            m_color = bus.piece_color;
        end
        @(posedge clk); #1;
        if (q.size() >= 2) begin
            got = q.pop_front();
            have = 1'b1;
            chk("rgb", bus.rgb, got.rgb);
            chk("hsync_out", {11'd0, bus.hsync_out}, {11'd0, got.hs});
            chk("vsync_out", {11'd0, bus.vsync_out}, {11'd0, got.vs});
        end
        @(negedge clk);
        bus.p_tick = 1'b0;
        @(posedge clk); #1;
        if (have) chk("rgb_hold", bus.rgb, got.rgb);
    endtask

    task automatic px(input int x, input int y, input bit vo = 1'b1,
                      input bit hs = 1'b0, input bit vs = 1'b0);
        drive(x, y, vo, hs, vs, model(x, y, vo));
    endtask

    task automatic piece_samples();
        for (int r = 17; r < 20; r++)
            for (int c = 6; c < 10; c++)
                px(240 + c * 16 + 8, 80 + r * 16 + 8);
        px(368, 368);
    endtask

    initial begin
        reset = 1'b1;
        bus.p_tick = 1'b0; bus.x = 10'd0; bus.y = 10'd0;
        bus.video_on = 1'b0; bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
        bus.piece_en = 1'b0; bus.piece_mask = 16'h0000; bus.piece_row = 5'd0;
        bus.piece_col = 4'd0; bus.piece_color = 3'd0;
        for (int i = 0; i < 256; i++) ram[i] = 3'd0;
        ram[0] = 3'd5; ram[9] = 3'd7; ram[10] = 3'd6; ram[190] = 3'd2; ram[199] = 3'd3;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rgb", bus.rgb, 12'h000);
        chk("reset_hsync", {11'd0, bus.hsync_out}, 12'h000);
        chk("reset_vsync", {11'd0, bus.vsync_out}, 12'h000);
        chk("reset_addr", {4'd0, bus.cell_addr}, 12'h000);
        @(negedge clk);
        reset = 1'b0;
        clear_model();

        // x, y, video_on, hsync, vsync, expected rgb, expected cell_addr (-1 none)
        tbl[0]  = '{240,  80, 1'b1, 1'b0, 1'b0, 12'h700,   0};
        tbl[1]  = '{248,  88, 1'b1, 1'b1, 1'b0, 12'hF00,   0};
        tbl[2]  = '{399, 399, 1'b1, 1'b0, 1'b1, 12'h507, 199};
        tbl[3]  = '{392, 392, 1'b1, 1'b1, 1'b1, 12'hA0F, 199};
        tbl[4]  = '{248, 104, 1'b1, 1'b0, 1'b0, 12'h00F,  10};
        tbl[5]  = '{392,  88, 1'b1, 1'b0, 1'b0, 12'hF80,   9};
        tbl[6]  = '{248, 392, 1'b1, 1'b0, 1'b0, 12'hFF0, 190};
        tbl[7]  = '{235, 200, 1'b1, 1'b0, 1'b0, 12'h000,  -1};
        tbl[8]  = '{236, 200, 1'b1, 1'b0, 1'b0, 12'hFFF,  -1};
        tbl[9]  = '{240, 200, 1'b1, 1'b0, 1'b0, 12'h111,  70};
        tbl[10] = '{256, 200, 1'b1, 1'b0, 1'b0, 12'h111,  71};
        tbl[11] = '{403, 200, 1'b1, 1'b0, 1'b0, 12'hFFF,  -1};
        tbl[12] = '{404, 200, 1'b1, 1'b0, 1'b0, 12'h000,  -1};
        tbl[13] = '{300,  75, 1'b1, 1'b0, 1'b0, 12'h000,  -1};
        tbl[14] = '{300,  76, 1'b1, 1'b0, 1'b0, 12'hFFF,  -1};
        tbl[15] = '{300, 404, 1'b1, 1'b0, 1'b0, 12'h000,  -1};
        tbl[16] = '{250,  90, 1'b0, 1'b0, 1'b0, 12'h000,   0};
        tbl[17] = '{300, 403, 1'b1, 1'b0, 1'b0, 12'hFFF,  -1};
        foreach (tbl[i]) begin
            drive(tbl[i].x, tbl[i].y, tbl[i].vo, tbl[i].hs, tbl[i].vs, tbl[i].rgb);
            if (tbl[i].addr >= 0) chk("cell_addr", {4'd0, bus.cell_addr}, 12'(tbl[i].addr));
        end

        // Row sweep across border and interior of an empty board row.
        for (int x = 230; x <= 410; x++) px(x, 200);

        // Horizontal and vertical sync pulses during blanking.
        for (int x = 650; x <= 760; x++) px(x, 300, 1'b0, (x >= 656 && x <= 751), 1'b0);
        for (int y = 510; y <= 516; y++) px(0, y, 1'b0, 1'b0, (y >= 513 && y <= 514));

        // Piece overlay with a coloured board underneath.
        for (int i = 0; i < 200; i++) ram[i] = 3'(i % 8);
        bus.piece_en = 1'b1; bus.piece_mask = 16'h0033; bus.piece_row = 5'd18;
        bus.piece_col = 4'd8; bus.piece_color = 3'd1;
        piece_samples();          // not yet latched
        px(0, 480);
        piece_samples();          // piece visible
        chk("piece_centre", model(376, 376, 1'b1), 12'h0FF);
        bus.piece_mask = 16'hFFFF; bus.piece_col = 4'd0; bus.piece_color = 3'd5;
        piece_samples();          // mid-frame change ignored
        px(248, 376);
        px(0, 480);
        piece_samples();          // new piece, clipped below the board
        px(248, 376);
        px(248, 376, 1'b0);
        px(376, 376, 1'b0);

        // Asynchronous reset in the middle of a visible, synced pixel stream.
        px(248, 88, 1'b1, 1'b1, 1'b1);
        px(248, 88, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset_rgb", bus.rgb, 12'h000);
        chk("midreset_hsync", {11'd0, bus.hsync_out}, 12'h000);
        chk("midreset_vsync", {11'd0, bus.vsync_out}, 12'h000);
        repeat (3) @(posedge clk);
        #1;
        chk("midreset_hold_rgb", bus.rgb, 12'h000);
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        px(248, 88, 1'b1, 1'b1, 1'b0);
        px(376, 376);
        px(392, 392);
        px(0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
